// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with a start/done
// handshake and a parallel registered result that only updates when a sum completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             s_bit, c_next;
  logic             accept, last_step;

  // Handshake: start is a request sampled on a rising edge whenever the block is
  // not in RUN (IDLE or DONE); an accepted start captures a/b/cin on that edge.
  // done is a single-cycle pulse asserted while sum/cout first show a new result.
  assign s_bit     = a_sh[0] ^ b_sh[0] ^ c_q;
  assign c_next    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_q) | (b_sh[0] & c_q);
  assign accept    = start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      r_sh  <= '0;
      c_q   <= cin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      r_sh  <= {s_bit, r_sh[WIDTH-1:1]};
      c_q   <= c_next;
      // Hold on the final step so the narrow counter never wraps.
      if (!last_step) cnt_q <= cnt_q + CW'(1);
    end
  end

  // The result register is published only on the RUN->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_step) begin
      sum  <= {s_bit, r_sh[WIDTH-1:1]};
      cout <= c_next;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed plus randomized checks of serial_adder against a plain-arithmetic
// model of {cout, sum} = a + b + cin and the start/done cycle timing.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_res = '0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[WIDTH:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; pulse_at >= 0 re-pulses start that many cycles into RUN.
  task automatic run_op(input logic [WIDTH-1:0] ta, tb_v, input logic tc, input int pulse_at);
    int  busy_cnt;
    bit  got;
    logic [WIDTH:0] e;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < WIDTH + 4 && !got; i++) begin
      if (done) got = 1;
      else begin
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        chk("held_result", {23'd0, cout, sum}, {23'd0, last_res});
        busy_cnt++;
        start = (busy_cnt == pulse_at + 1) && (pulse_at >= 0);
        if (start) begin a = 8'h11; b = 8'h22; end
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk("done_timeout", {31'd0, got}, 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      chk("result", {23'd0, cout, sum}, {23'd0, e});
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("busy_cycles", busy_cnt, WIDTH);
      last_res = e;
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic no_done_for(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {23'd0, cout, sum}, 32'd0);
    rst_n = 1'b1;
    no_done_for("no_done_after_reset", 3);

    // Directed vectors
    run_op(8'h3C, 8'h5A, 1'b0, -1);
    chk("vec_3c_5a", {23'd0, last_res}, 32'h096);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    chk("vec_ff_01", {23'd0, last_res}, 32'h100);
    run_op(8'h00, 8'h00, 1'b1, -1);
    chk("vec_00_00_c", {23'd0, last_res}, 32'h001);
    run_op(8'hFF, 8'hFF, 1'b1, -1);
    chk("vec_ff_ff_c", {23'd0, last_res}, 32'h1FF);

    // Start pulse three cycles into RUN must be ignored
    run_op(8'h3C, 8'h5A, 1'b1, 3);
    chk("ignored_start_res", {23'd0, last_res}, 32'h097);
    no_done_for("ignored_start_no_extra_done", WIDTH + 2);

    // Randomized single operations
    for (int k = 0; k < 20; k++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), -1);

    // start held high: accepted edges every WIDTH+1 cycles, operands change every cycle
    for (int n = 0; n <= 9 * 6; n++) begin
      @(negedge clk);
      if (n > 0) begin
        chk("b2b_done", {31'd0, done}, {31'd0, (n % (WIDTH + 1)) == 0});
        chk("b2b_busy", {31'd0, busy}, {31'd0, (n % (WIDTH + 1)) != 0});
        if (done) begin
          last_res = exp_q.pop_front();
          chk("b2b_result", {23'd0, cout, sum}, {23'd0, last_res});
        end
      end
      if (n == 9 * 6) start = 1'b0;
      else begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        start = 1'b1;
        if (n % (WIDTH + 1) == 0) exp_q.push_back(model(a, b, cin));
      end
    end
    @(negedge clk);
    chk("b2b_drained", exp_q.size(), 0);

    // Reset in the middle of RUN
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_res", {23'd0, cout, sum}, 32'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for("abort_no_done", WIDTH + 4);
    run_op(8'h80, 8'h80, 1'b0, -1);
    chk("after_abort", {23'd0, last_res}, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
